// File: rtl/step_ramp_gen_pkg.sv
// Shared types and default widths for the step ramp generator.
package step_ramp_gen_pkg;

  localparam int unsigned DEF_PERIOD_W = 24;
  localparam int unsigned DEF_STEP_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEL,
    ST_CRUISE,
    ST_DECEL
  } state_e;

  typedef enum logic {
    MODE_CONT,
    MODE_COUNTED
  } mode_e;

endpackage

// File: rtl/step_ramp_gen_timer.sv
// Step interval down-counter: load, decrement enable, terminal-count flag.
module step_period_timer
  import step_ramp_gen_pkg::*;
#(
  parameter int unsigned W = DEF_PERIOD_W
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/step_ramp_gen.sv
// Step strobe generator with linear accel/decel profile, continuous and counted modes.
module step_ramp_gen
  import step_ramp_gen_pkg::*;
#(
  parameter int unsigned PERIOD_W     = DEF_PERIOD_W,
  parameter int unsigned STEP_W       = DEF_STEP_W,
  parameter int unsigned START_PERIOD = 100000,
  parameter int unsigned MIN_PERIOD   = 5000,
  parameter int unsigned RAMP_DEC     = 2000
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                run,
  input  logic                move_start,
  input  logic [STEP_W-1:0]   move_steps,
  input  logic [PERIOD_W-1:0] target_period,
  output logic                en,
  output logic                busy,
  output logic                move_done,
  output logic [PERIOD_W-1:0] cur_period
);

  localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] RAMP_P  = PERIOD_W'(RAMP_DEC);
  localparam logic [PERIOD_W-1:0] ONE_P   = PERIOD_W'(1);
  localparam logic [STEP_W-1:0]   ONE_S   = STEP_W'(1);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
  logic [PERIOD_W-1:0] tgt_q, tgt_d;
  logic [STEP_W-1:0]   ramp_q, ramp_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pend_q, pend_d;

  logic                tmr_tc;
  logic                tmr_load;
  logic [PERIOD_W-1:0] tmr_val;
  logic                step_evt;
  logic                exit_idle;
  logic [PERIOD_W-1:0] tgt_clamp;
  logic [PERIOD_W-1:0] per_sub, per_dn, per_up;
  logic [PERIOD_W:0]   per_sum;

  assign step_evt = (state_q != ST_IDLE) && tmr_tc;

  step_period_timer #(
    .W (PERIOD_W)
  ) u_timer (
    .clk        (clk),
    .resetb     (resetb),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (state_q != ST_IDLE),
    .tc_o       (tmr_tc)
  );

  // Saturating period arithmetic and target clamp.
  always_comb begin
    tgt_clamp = target_period;
    if (target_period < MIN_P) begin
      tgt_clamp = MIN_P;
    end else if (target_period > START_P) begin
      tgt_clamp = START_P;
    end
    per_sub = (cur_period_q > RAMP_P) ? (cur_period_q - RAMP_P) : '0;
    per_dn  = (per_sub < tgt_q) ? tgt_q : per_sub;
    per_sum = {1'b0, cur_period_q} + {1'b0, RAMP_P};
    per_up  = (per_sum > {1'b0, START_P}) ? START_P : per_sum[PERIOD_W-1:0];
  end

  // Profile next-state: step-event updates first, then continuous-mode run overrides.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cur_period_d = cur_period_q;
    tgt_d        = tgt_q;
    ramp_d       = ramp_q;
    steps_d      = steps_q;
    en_d         = 1'b0;
    done_d       = pend_q;
    pend_d       = 1'b0;
    exit_idle    = 1'b0;
    tmr_load     = 1'b0;

    if (state_q == ST_IDLE) begin
      if (move_start) begin
        if (move_steps == '0) begin
          done_d = 1'b1;
        end else begin
          mode_d    = MODE_COUNTED;
          steps_d   = move_steps;
          exit_idle = 1'b1;
        end
      end else if (run) begin
        mode_d    = MODE_CONT;
        exit_idle = 1'b1;
      end
      if (exit_idle) begin
        state_d      = ST_ACCEL;
        cur_period_d = START_P;
        tgt_d        = tgt_clamp;
        ramp_d       = '0;
        tmr_load     = 1'b1;
      end
    end else begin
      if (step_evt) begin
        en_d     = 1'b1;
        tmr_load = 1'b1;
        case (state_q)
          ST_ACCEL: begin
            cur_period_d = per_dn;
            if ((per_dn != cur_period_q) && (ramp_q != '1)) begin
              ramp_d = ramp_q + ONE_S;
            end
            if (per_dn == tgt_q) begin
              state_d = ST_CRUISE;
            end
          end
          ST_DECEL: begin
            cur_period_d = per_up;
            ramp_d       = (ramp_q == '0) ? '0 : (ramp_q - ONE_S);
            if ((mode_q == MODE_CONT) && (ramp_d == '0)) begin
              state_d = ST_IDLE;
            end
          end
          default: ;
        endcase
        if (mode_q == MODE_COUNTED) begin
          steps_d = (steps_q == '0) ? '0 : (steps_q - ONE_S);
          if (steps_d == '0) begin
            state_d = ST_IDLE;
            pend_d  = 1'b1;
          end else if (steps_d <= ramp_d) begin
            state_d = ST_DECEL;
          end
        end
      end
      if ((mode_q == MODE_CONT) && (state_d != ST_IDLE)) begin
        if (!run && ((state_d == ST_ACCEL) || (state_d == ST_CRUISE))) begin
          state_d = (ramp_d == '0) ? ST_IDLE : ST_DECEL;
        end else if (run && (state_d == ST_DECEL)) begin
          state_d = ST_ACCEL;
        end
      end
    end

    busy_d  = (state_d != ST_IDLE);
    tmr_val = (cur_period_d == '0) ? '0 : (cur_period_d - ONE_P);
  end

  // Profile FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_CONT;
      cur_period_q <= START_P;
      tgt_q        <= START_P;
      ramp_q       <= '0;
      steps_q      <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cur_period_q <= cur_period_d;
      tgt_q        <= tgt_d;
      ramp_q       <= ramp_d;
      steps_q      <= steps_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pend_q       <= pend_d;
    end
  end

  assign en         = en_q;
  assign busy       = busy_q;
  assign move_done  = done_q;
  assign cur_period = cur_period_q;

endmodule

// File: tb/tb_step_ramp_gen.sv
// Directed bench for step_ramp_gen with START=100, MIN=20, RAMP_DEC=10.
module tb_step_ramp_gen;

  localparam int unsigned PW = 24;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          resetb;
  logic          run;
  logic          move_start;
  logic [SW-1:0] move_steps;
  logic [PW-1:0] target_period;
  logic          en;
  logic          busy;
  logic          move_done;
  logic [PW-1:0] cur_period;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  int SEQ_T1[16] = '{100, 90, 80, 70, 60, 50, 60, 70, 80, 90, 0, 0, 0, 0, 0, 0};
  int SEQ_UP[16] = '{100, 90, 80, 70, 60, 50, 40, 30, 20, 20, 20, 0, 0, 0, 0, 0};
  int SEQ_DN[16] = '{20, 30, 40, 50, 60, 70, 80, 90, 0, 0, 0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  // Running count of move_done pulses.
  always @(negedge clk) if (move_done === 1'b1) done_seen++;

  step_ramp_gen #(
    .PERIOD_W     (PW),
    .STEP_W       (SW),
    .START_PERIOD (100),
    .MIN_PERIOD   (20),
    .RAMP_DEC     (10)
  ) dut (
    .clk           (clk),
    .resetb        (resetb),
    .run           (run),
    .move_start    (move_start),
    .move_steps    (move_steps),
    .target_period (target_period),
    .en            (en),
    .busy          (busy),
    .move_done     (move_done),
    .cur_period    (cur_period)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles until the next en, counted in negedges; -1 on timeout.
  task automatic wait_en(output int dt);
    dt = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (en === 1'b1) begin
        dt = n;
        break;
      end
    end
  endtask

  task automatic expect_seq(input string tag, input int exp[16], input int first, input int last);
    int dt;
    for (int i = first; i <= last; i++) begin
      wait_en(dt);
      check($sformatf("%s[%0d]", tag, i), dt, exp[i]);
    end
  endtask

  task automatic quiet(input int n, output int ens, output int dones);
    ens = 0;
    dones = 0;
    repeat (n) begin
      @(negedge clk);
      if (en === 1'b1) ens++;
      if (move_done === 1'b1) dones++;
    end
  endtask

  task automatic pulse_move(input int steps);
    move_steps = SW'(steps);
    move_start = 1'b1;
    @(negedge clk);
    move_start = 1'b0;
  endtask

  task automatic run_t1(input string tag);
    int e, d;
    target_period = 50;
    pulse_move(10);
    expect_seq(tag, SEQ_T1, 0, 9);
    check({tag, "_busy_low"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done"}, move_done, 1'b1);
    check({tag, "_no_en_at_done"}, en, 1'b0);
    quiet(200, e, d);
    check({tag, "_quiet_en"}, e, 0);
    check({tag, "_quiet_done"}, d, 0);
  endtask

  initial begin
    int dt, e, d, d0;
    resetb = 1'b0;
    run = 1'b0;
    move_start = 1'b0;
    move_steps = '0;
    target_period = 50;
    repeat (3) @(negedge clk);
    check("rst_en", en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", move_done, 1'b0);
    check("rst_period", cur_period, 100);
    resetb = 1'b1;
    @(negedge clk);

    // Counted move of 10 steps, cruise target 50.
    run_t1("t1");

    // Continuous ramp to 20, then ramp down after run drops.
    d0 = done_seen;
    target_period = 20;
    run = 1'b1;
    @(negedge clk);
    expect_seq("t2_up", SEQ_UP, 0, 10);
    check("t2_cruise_period", cur_period, 20);
    run = 1'b0;
    expect_seq("t2_dn", SEQ_DN, 0, 7);
    check("t2_busy_low", busy, 1'b0);
    check("t2_period_back", cur_period, 100);
    quiet(200, e, d);
    check("t2_quiet_en", e, 0);
    check("t2_no_done", done_seen - d0, 0);

    // Clamp low: target 5 cruises at 20.
    target_period = 5;
    run = 1'b1;
    @(negedge clk);
    expect_seq("t3lo", SEQ_UP, 0, 9);
    check("t3lo_period", cur_period, 20);
    run = 1'b0;
    expect_seq("t3lo_dn", SEQ_DN, 0, 7);
    quiet(50, e, d);

    // Clamp high: target 500 runs flat at 100; drop with ramp_cnt=0 goes straight idle.
    target_period = 500;
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wait_en(dt);
      check($sformatf("t3hi[%0d]", i), dt, 100);
    end
    run = 1'b0;
    @(negedge clk);
    check("t3hi_idle", busy, 1'b0);
    quiet(200, e, d);
    check("t3hi_no_en", e, 0);

    // Zero-step move: done next cycle, no en.
    target_period = 50;
    pulse_move(0);
    check("t4z_done", move_done, 1'b1);
    check("t4z_busy", busy, 1'b0);
    quiet(150, e, d);
    check("t4z_no_en", e, 0);
    check("t4z_single_done", d, 0);

    // One-step move.
    pulse_move(1);
    wait_en(dt);
    check("t4one_dt", dt, 100);
    check("t4one_busy", busy, 1'b0);
    @(negedge clk);
    check("t4one_done", move_done, 1'b1);
    quiet(150, e, d);
    check("t4one_no_en", e, 0);

    // run and move_start together: counted 2-step move (100, 90) then done.
    run = 1'b1;
    pulse_move(2);
    expect_seq("t4both", SEQ_T1, 0, 1);
    run = 1'b0;
    check("t4both_busy", busy, 1'b0);
    @(negedge clk);
    check("t4both_done", move_done, 1'b1);
    quiet(200, e, d);
    check("t4both_no_en", e, 0);

    // Ignored inputs while busy. The stray move_start pulse takes one
    // negedge out of the second interval, so it reads 89.
    target_period = 50;
    pulse_move(10);
    wait_en(dt);
    check("t5_first", dt, 100);
    target_period = 90;
    pulse_move(3);
    wait_en(dt);
    check("t5_second", dt, 89);
    expect_seq("t5", SEQ_T1, 2, 9);
    @(negedge clk);
    check("t5_done", move_done, 1'b1);
    quiet(100, e, d);
    check("t5_no_en", e, 0);

    // Early run drop before the first en.
    run = 1'b1;
    @(negedge clk);
    repeat (49) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("t5early_idle", busy, 1'b0);
    quiet(200, e, d);
    check("t5early_no_en", e, 0);

    // Reset during cruise of a 20-step move.
    target_period = 50;
    pulse_move(20);
    expect_seq("t6", SEQ_T1, 0, 5);
    resetb = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    check("t6_en", en, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_period", cur_period, 100);
    check("t6_done", move_done, 1'b0);
    quiet(300, e, d);
    check("t6_no_en", e, 0);
    check("t6_no_done", d, 0);
    run_t1("t6_again");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
